// File: rtl/run_ctrl.sv
// Run controller: holds the core in reset, then watches the fetch PC to flag
// halt (PC stuck) or timeout (cycle budget spent), with a PC-change trace.
module run_ctrl #(
    parameter int PC_WIDTH       = 32,
    parameter int CNT_WIDTH      = 16,
    parameter int RST_CYCLES     = 1,
    parameter int HALT_REPEAT    = 4,
    parameter int TIMEOUT_CYCLES = 270
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fwd_sel,
    input  logic [PC_WIDTH-1:0]  pc,
    output logic                 core_rst,
    output logic                 has_forwarding,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] pc_change_count,
    output logic                 trace_valid,
    output logic [PC_WIDTH-1:0]  trace_pc,
    output logic                 halted,
    output logic                 timed_out,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2,
        S_TMO  = 2'd3
    } state_e;

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int SAME_W = (HALT_REPEAT > 2) ? $clog2(HALT_REPEAT - 1) : 1;

    state_e                state_q;
    logic [HOLD_W-1:0]     hold_cnt_q;
    logic [SAME_W-1:0]     same_cnt_q;
    logic [PC_WIDTH-1:0]   prev_pc_q;
    logic [PC_WIDTH-1:0]   trace_pc_q;
    logic                  trace_valid_q;
    logic                  has_fwd_q;
    logic [CNT_WIDTH-1:0]  cycle_q;
    logic [CNT_WIDTH-1:0]  pc_change_q;

    logic                  pc_changed;
    logic                  halt_hit;
    logic                  tmo_hit;
    logic [CNT_WIDTH-1:0]  cycle_d;
    logic [CNT_WIDTH-1:0]  pc_change_d;

    // NOTE: every signal gets a value on every pass through always_comb, so no latch is inferred.
    always_comb begin
        pc_changed  = (pc != prev_pc_q);
        cycle_d     = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;
        pc_change_d = (pc_change_q == '1) ? pc_change_q : pc_change_q + 1'b1;
        halt_hit    = !pc_changed && (same_cnt_q == SAME_W'(HALT_REPEAT - 2));
        tmo_hit     = (cycle_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_HOLD;
            hold_cnt_q    <= '0;
            same_cnt_q    <= '0;
            prev_pc_q     <= '0;
            trace_pc_q    <= '0;
            trace_valid_q <= 1'b0;
            has_fwd_q     <= 1'b0;
            cycle_q       <= '0;
            pc_change_q   <= '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    hold_cnt_q <= hold_cnt_q + 1'b1;
                    if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
                        state_q   <= S_RUN;
                        has_fwd_q <= fwd_sel;
                        prev_pc_q <= pc;
                    end
                end
                S_RUN: begin
                    cycle_q <= cycle_d;
                    if (pc_changed) begin
                        prev_pc_q   <= pc;
                        trace_pc_q  <= pc;
                        // A change on the timeout edge is counted but not pulsed: TMO shows no trace.
                        trace_valid_q <= !tmo_hit;
                        pc_change_q <= pc_change_d;
                        same_cnt_q  <= '0;
                    end else begin
                        trace_valid_q <= 1'b0;
                        same_cnt_q    <= same_cnt_q + 1'b1;
                    end
                    if (halt_hit) begin
                        state_q <= S_HALT;
                    end else if (tmo_hit) begin
                        state_q <= S_TMO;
                    end
                end
                default: begin
                    trace_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign core_rst        = (state_q == S_HOLD);
    assign has_forwarding  = has_fwd_q;
    assign state           = state_q;
    assign cycle_count     = cycle_q;
    assign pc_change_count = pc_change_q;
    assign trace_valid     = trace_valid_q;
    assign trace_pc        = trace_pc_q;
    assign halted          = (state_q == S_HALT);
    assign timed_out       = (state_q == S_TMO);
    assign done            = halted | timed_out;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: a run-length model predicts trace pulses and
// the terminal state; a negedge monitor pops and compares what the DUT shows.
module tb_run_ctrl;

    localparam int PCW     = 32;
    localparam int CW      = 16;
    localparam int RSTC    = 3;
    localparam int HREP    = 4;
    localparam int TMO     = 10;
    localparam int BUDGET  = 20;

    localparam int M_STEP   = 0;
    localparam int M_FREEZE = 1;
    localparam int M_HALT10 = 2;
    localparam int M_RAND   = 3;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic [CW-1:0]  cnt;
    } trace_t;

    typedef struct packed {
        logic [1:0]    st;
        logic [CW-1:0] cyc;
        logic [CW-1:0] pcc;
    } end_t;

    logic           clk;
    logic           clk_en;
    logic           rst;
    logic           fwd_sel;
    logic [PCW-1:0] pc;
    logic           core_rst;
    logic           has_forwarding;
    logic [1:0]     state;
    logic [CW-1:0]  cycle_count;
    logic [CW-1:0]  pc_change_count;
    logic           trace_valid;
    logic [PCW-1:0] trace_pc;
    logic           halted;
    logic           timed_out;
    logic           done;

    int n_checks = 0;
    int n_fail   = 0;

    trace_t      trace_q[$];
    end_t        end_q[$];
    int unsigned pc_seq[0:BUDGET];

    run_ctrl #(
        .PC_WIDTH(PCW), .CNT_WIDTH(CW), .RST_CYCLES(RSTC),
        .HALT_REPEAT(HREP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .fwd_sel(fwd_sel), .pc(pc),
        .core_rst(core_rst), .has_forwarding(has_forwarding), .state(state),
        .cycle_count(cycle_count), .pc_change_count(pc_change_count),
        .trace_valid(trace_valid), .trace_pc(trace_pc),
        .halted(halted), .timed_out(timed_out), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset();
        check("rst_state", state, 0);
        check("rst_core_rst", core_rst, 1);
        check("rst_has_fwd", has_forwarding, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_pc_change_count", pc_change_count, 0);
        check("rst_trace_valid", trace_valid, 0);
        check("rst_trace_pc", trace_pc, 0);
        check("rst_done_flags", {halted, timed_out, done}, 0);
    endtask

    // Monitor: consumes expectations only when the DUT presents a pulse or finishes.
    trace_t mon_t;
    end_t   mon_e;
    logic   done_prev = 1'b0;
    always @(negedge clk) begin
        if (trace_valid === 1'b1) begin
            if (trace_q.size() == 0) begin
                check("trace_unexpected", trace_valid, 0);
            end else begin
                mon_t = trace_q.pop_front();
                check("trace_pc", trace_pc, mon_t.pc);
                check("trace_pc_change_count", pc_change_count, mon_t.cnt);
            end
        end
        if (done === 1'b1 && !done_prev) begin
            if (end_q.size() == 0) begin
                check("done_unexpected", done, 0);
            end else begin
                mon_e = end_q.pop_front();
                check("end_state", state, mon_e.st);
                check("end_cycle_count", cycle_count, mon_e.cyc);
                check("end_pc_change_count", pc_change_count, mon_e.pcc);
                check("end_halted", halted, mon_e.st == 2);
                check("end_timed_out", timed_out, mon_e.st == 3);
            end
        end
        done_prev = (done === 1'b1);
    end

    task automatic build_seq(input int mode);
        pc_seq[0] = (mode == M_HALT10) ? 100 : ((mode == M_FREEZE) ? 'h28 : 0);
        if (mode == M_RAND) pc_seq[0] = $urandom_range(0, 7) * 4;
        for (int i = 1; i <= BUDGET; i++) begin
            case (mode)
                M_STEP:   pc_seq[i] = i * 4;
                M_FREEZE: pc_seq[i] = 'h28;
                M_HALT10: pc_seq[i] = (i <= 7) ? 100 + i * 4 : 100 + 7 * 4;
                default:  pc_seq[i] = ($urandom_range(0, 9) < 7) ? pc_seq[i-1]
                                                                  : $urandom_range(0, 7) * 4;
            endcase
        end
    endtask

    // Entered just after a negedge with rst high; returns the same way.
    task automatic do_run(input int mode, input logic fwd, input int abort_at);
        int unsigned last, run_len, cyc, pcc, tpc;
        int          k;
        int          st;
        bit          changed;

        build_seq(mode);
        fwd_sel = fwd;
        pc      = pc_seq[0];
        rst     = 1'b0;
        for (int i = 1; i <= RSTC; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            if (i < RSTC) begin
                check("hold_core_rst", core_rst, 1);
                check("hold_state", state, 0);
            end else begin
                check("entry_state", state, 1);
                check("entry_core_rst", core_rst, 0);
                check("entry_has_fwd", has_forwarding, fwd);
                check("entry_cycle_count", cycle_count, 0);
                check("entry_trace_valid", trace_valid, 0);
            end
        end

        // Model: length of the current run of equal PC samples, counting the entry sample.
        last = pc_seq[0]; run_len = 1; cyc = 0; pcc = 0; tpc = 0; st = 1; k = 0;
        while (st == 1 && k < BUDGET) begin
            k++;
            pc      = pc_seq[k];
            fwd_sel = 1'($urandom_range(0, 1));
            @(posedge clk);
            cyc++;
            changed = (pc_seq[k] != last);
            if (changed) begin
                last = pc_seq[k]; tpc = last; pcc++; run_len = 1;
            end else begin
                run_len++;
            end
            if (!changed && run_len == HREP) st = 2;
            else if (cyc == TMO) st = 3;
            if (changed && st == 1) trace_q.push_back(trace_t'{pc: PCW'(tpc), cnt: CW'(pcc)});
            if (st != 1) end_q.push_back(end_t'{st: 2'(st), cyc: CW'(cyc), pcc: CW'(pcc)});
            @(negedge clk);
            #1;
            if (abort_at != 0 && k == abort_at) begin
                check("abort_cycle_count", cycle_count, cyc);
                check("abort_trace_left", trace_q.size(), 0);
                trace_q.delete();
                end_q.delete();
                clk_en = 1'b0;
                rst    = 1'b1;
                #2;
                check_reset();
                clk_en = 1'b1;
                @(negedge clk);
                return;
            end
        end

        for (int i = 0; i < 10; i++) begin
            pc      = $urandom;
            fwd_sel = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        check("frozen_state", state, st);
        check("frozen_cycle_count", cycle_count, cyc);
        check("frozen_pc_change_count", pc_change_count, pcc);
        check("frozen_trace_pc", trace_pc, tpc);
        check("frozen_trace_valid", trace_valid, 0);
        check("frozen_has_fwd", has_forwarding, fwd);
        check("frozen_core_rst", core_rst, 0);
        check("frozen_done", done, 1);
        check("trace_q_left", trace_q.size(), 0);
        check("end_q_left", end_q.size(), 0);
        trace_q.delete();
        end_q.delete();

        rst = 1'b1;
        #1;
        check_reset();
        @(negedge clk);
    endtask

    initial begin
        clk_en  = 1'b0;
        rst     = 1'b0;
        pc      = '0;
        fwd_sel = 1'b0;
        #1 rst  = 1'b1;
        #1;
        check_reset();
        clk_en = 1'b1;
        @(negedge clk);

        do_run(M_STEP,   1'b1, 0);
        do_run(M_FREEZE, 1'b0, 0);
        do_run(M_HALT10, 1'b1, 0);
        do_run(M_STEP,   1'b0, 5);
        do_run(M_STEP,   1'b1, 0);
        for (int r = 0; r < 10; r++) begin
            do_run(M_RAND, 1'($urandom_range(0, 1)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
